data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 127 ++++++++++++
 tb/tb_data_ram.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// data_ram: word-addressed data RAM with byte-lane writes, plus a small
// MMIO timer window (COUNT, COMPARE, STATUS, SCRATCH) that raises a
// level interrupt when the free-running counter hits the compare value.
module data_ram #(
  parameter int         DEPTH_LOG2 = 10,
  parameter logic [3:0] MMIO_TAG   = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        timer_irq_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_COMPARE = 2'd1,
    REG_STATUS  = 2'd2,
    REG_SCRATCH = 2'd3
  } mmio_reg_e;

  logic [31:0] mem [DEPTH];

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] scratch_q, scratch_d;
  logic        status_q,  status_d;

  logic                  mmio_hit;
  logic [DEPTH_LOG2-1:0] word_idx;
  mmio_reg_e             reg_sel;
  logic                  wr_en;
  logic                  ram_we;
  logic                  mmio_we;
  logic                  match;
  logic                  unused_addr;

  // Merge new bytes into an old word on the lanes enabled by sel.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign mmio_hit    = (addr[31:28] == MMIO_TAG);
  assign word_idx    = addr[DEPTH_LOG2+1:2];
  assign reg_sel     = mmio_reg_e'(addr[3:2]);
  assign wr_en       = ce && we && !rst;
  assign ram_we      = wr_en && !mmio_hit;
  assign mmio_we     = wr_en && mmio_hit;
  assign match       = (compare_q != 32'h0) && (count_q == compare_q);
  assign timer_irq_o = status_q;
  // Address bits outside the RAM index and register select are don't-care.
  assign unused_addr = ^addr;

  // Combinational read path; zero whenever no read is in progress.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    data_o = 32'h0;
    if (ce && !we && !rst) begin
      if (mmio_hit) begin
        case (reg_sel)
          REG_COUNT:   data_o = count_q;
          REG_COMPARE: data_o = compare_q;
          REG_STATUS:  data_o = {31'h0, status_q};
          REG_SCRATCH: data_o = scratch_q;
          default:     data_o = 32'h0;
        endcase
      end else begin
        data_o = mem[word_idx];
      end
    end
  end

  // Next-state for the timer registers; a match set beats a W1C clear.
  always_comb begin
    count_d   = count_q + 32'h1;
    compare_d = compare_q;
    scratch_d = scratch_q;
    status_d  = status_q;
    if (mmio_we) begin
      case (reg_sel)
        REG_COMPARE: compare_d = lane_merge(compare_q, data_i, sel);
        REG_STATUS:  if (sel[0] && data_i[0]) status_d = 1'b0;
        REG_SCRATCH: scratch_d = lane_merge(scratch_q, data_i, sel);
        default:     ;
      endcase
    end
    if (match) status_d = 1'b1;
  end

  // Timer register state with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      scratch_q <= 32'h0;
      status_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      scratch_q <= scratch_d;
      status_q  <= status_d;
    end
  end

  // RAM byte-lane writes.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto block memory; contents are undefined until written.
    for (int i = 0; i < 4; i++) begin
      if (ram_we && sel[i]) mem[word_idx][8*i +: 8] <= data_i[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: table-driven check of data_ram. Each phase builds a list of
// one-cycle vectors; expected results go into a scoreboard queue when the
// vector is driven and are popped and compared when the outputs settle.
module tb_data_ram;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        timer_irq_o;

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        irq;
  } exp_t;

  vec_t  vecs[$];
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase;

  localparam logic [31:0] A_COUNT   = 32'h1000_0000;
  localparam logic [31:0] A_COMPARE = 32'h1000_0004;
  localparam logic [31:0] A_STATUS  = 32'h1000_0008;
  localparam logic [31:0] A_SCRATCH = 32'h1000_000C;

  data_ram #(.DEPTH_LOG2(10), .MMIO_TAG(4'h1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .we          (we),
    .addr        (addr),
    .sel         (sel),
    .data_i      (data_i),
    .data_o      (data_o),
    .timer_irq_o (timer_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                    input logic irq);
    vec_t v;
    v = '{ce: 1'b1, we: 1'b1, addr: a, sel: s, data: d, exp_data: 32'h0, exp_irq: irq};
    vecs.push_back(v);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic irq);
    vec_t v;
    v = '{ce: 1'b1, we: 1'b0, addr: a, sel: 4'h0, data: 32'h0, exp_data: exp, exp_irq: irq};
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [31:0] a, input logic irq);
    vec_t v;
    v = '{ce: 1'b0, we: 1'b0, addr: a, sel: 4'hF, data: 32'hFFFF_FFFF, exp_data: 32'h0, exp_irq: irq};
    vecs.push_back(v);
  endtask

  // Entered and left at a falling edge; one vector per clock cycle.
  task automatic run_vecs();
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      ce     = vecs[i].ce;
      we     = vecs[i].we;
      addr   = vecs[i].addr;
      sel    = vecs[i].sel;
      data_i = vecs[i].data;
      exp_q.push_back('{data: vecs[i].exp_data, irq: vecs[i].exp_irq});
      #2;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d] data_o", phase, i), data_o, e.data);
      check($sformatf("%s[%0d] irq", phase, i), {31'h0, timer_irq_o}, {31'h0, e.irq});
      @(negedge clk);
    end
    vecs.delete();
    ce = 1'b0;
    we = 1'b0;
  endtask

  // One reset edge; returns at the falling edge of the first post-reset cycle.
  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b0;
    we  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'h0; sel = 4'h0; data_i = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // RAM: full write, lane write, empty-sel write, aliasing, overwrite.
    phase = "ram";
    wr(32'h0000_0100, 4'b1111, 32'hA1B2_C3D4, 1'b0);
    rd(32'h0000_0100, 32'hA1B2_C3D4, 1'b0);
    wr(32'h0000_0100, 4'b0100, 32'h00FF_0000, 1'b0);
    rd(32'h0000_0100, 32'hA1FF_C3D4, 1'b0);
    wr(32'h0000_0100, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    rd(32'h0000_0100, 32'hA1FF_C3D4, 1'b0);
    idle(32'h0000_0100, 1'b0);
    rd(32'h0000_1100, 32'hA1FF_C3D4, 1'b0);
    wr(32'h0000_0100, 4'b1111, 32'h1234_5678, 1'b0);
    rd(32'h0000_0100, 32'h1234_5678, 1'b0);
    wr(32'h0000_0104, 4'b1111, 32'h55AA_55AA, 1'b0);
    rd(32'h0000_0104, 32'h55AA_55AA, 1'b0);
    rd(32'h0000_0100, 32'h1234_5678, 1'b0);
    run_vecs();

    // Timer: vector i executes while COUNT == i.
    do_reset();
    phase = "timer";
    wr(A_COMPARE, 4'b1111, 32'd5, 1'b0);               // 0
    rd(A_COUNT, 32'd1, 1'b0);                          // 1
    rd(A_COMPARE, 32'd5, 1'b0);                        // 2
    wr(A_COUNT, 4'b1111, 32'h0000_FFFF, 1'b0);         // 3 ignored
    rd(A_COUNT, 32'd4, 1'b0);                          // 4
    rd(A_COUNT, 32'd5, 1'b0);                          // 5 match
    rd(A_STATUS, 32'd1, 1'b1);                         // 6
    rd(A_COUNT, 32'd7, 1'b1);                          // 7
    wr(A_STATUS, 4'b0001, 32'd1, 1'b1);                // 8 W1C
    rd(A_STATUS, 32'd0, 1'b0);                         // 9
    wr(A_COMPARE, 4'b0001, 32'hFFFF_FF0C, 1'b0);       // 10 lane 0 only -> 12
    rd(32'h1ABC_DEF4, 32'd12, 1'b0);                   // 11 aliased COMPARE
    wr(A_STATUS, 4'b0001, 32'd1, 1'b0);                // 12 match + W1C
    rd(A_STATUS, 32'd1, 1'b1);                         // 13 set wins
    wr(A_STATUS, 4'b0010, 32'hFFFF_FFFF, 1'b1);        // 14 lane 0 off
    rd(A_STATUS, 32'd1, 1'b1);                         // 15
    wr(A_STATUS, 4'b1111, 32'hFFFF_FFFE, 1'b1);        // 16 bit0 = 0
    rd(A_STATUS, 32'd1, 1'b1);                         // 17
    wr(A_STATUS, 4'b1111, 32'd1, 1'b1);                // 18
    rd(A_STATUS, 32'd0, 1'b0);                         // 19
    wr(A_SCRATCH, 4'b0011, 32'hDEAD_BEEF, 1'b0);       // 20
    rd(A_SCRATCH, 32'h0000_BEEF, 1'b0);                // 21
    rd(A_STATUS, 32'd0, 1'b0);                         // 22
    wr(A_COMPARE, 4'b1111, 32'd23, 1'b0);              // 23 old COMPARE used
    rd(A_STATUS, 32'd0, 1'b0);                         // 24
    rd(A_COMPARE, 32'd23, 1'b0);                       // 25
    rd(A_STATUS, 32'd0, 1'b0);                         // 26
    run_vecs();

    // Counter wrap with COMPARE = 0: preload COUNT just below the top.
    do_reset();
    force dut.count_q = 32'hFFFF_FFFC;
    #1;
    release dut.count_q;
    @(negedge clk);
    phase = "wrap";
    rd(A_COUNT, 32'hFFFF_FFFD, 1'b0);                  // 0
    rd(A_COUNT, 32'hFFFF_FFFE, 1'b0);                  // 1
    rd(A_COUNT, 32'hFFFF_FFFF, 1'b0);                  // 2
    rd(A_COUNT, 32'h0000_0000, 1'b0);                  // 3 count 0, no match
    rd(A_COUNT, 32'h0000_0001, 1'b0);                  // 4
    rd(A_STATUS, 32'd0, 1'b0);                         // 5
    wr(A_COMPARE, 4'b1111, 32'd9, 1'b0);               // 6
    wr(A_SCRATCH, 4'b0011, 32'hDEAD_BEEF, 1'b0);       // 7
    rd(A_SCRATCH, 32'h0000_BEEF, 1'b0);                // 8
    rd(A_COMPARE, 32'd9, 1'b0);                        // 9
    rd(A_COUNT, 32'd7, 1'b0);                          // 10
    rd(A_COUNT, 32'd8, 1'b0);                          // 11
    rd(A_COUNT, 32'd9, 1'b0);                          // 12 match
    rd(A_STATUS, 32'd1, 1'b1);                         // 13
    run_vecs();

    // Mid-operation reset: read output forced to 0, write suppressed.
    rst    = 1'b1;
    ce     = 1'b1;
    we     = 1'b0;
    addr   = A_COUNT;
    #2;
    check("rst read data_o", data_o, 32'h0);
    check("rst irq pre-edge", {31'h0, timer_irq_o}, 32'h1);
    we     = 1'b1;
    addr   = A_SCRATCH;
    sel    = 4'b1111;
    data_i = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b0;
    ce  = 1'b0;
    we  = 1'b0;
    phase = "post_rst";
    rd(A_COUNT, 32'd0, 1'b0);                          // 0
    rd(A_COMPARE, 32'd0, 1'b0);                        // 1
    rd(A_STATUS, 32'd0, 1'b0);                         // 2
    rd(A_SCRATCH, 32'd0, 1'b0);                        // 3
    rd(A_COUNT, 32'd4, 1'b0);                          // 4
    run_vecs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
